// File: rtl/arp_cam_rnd_idx_pkg.sv
// Shared types and helpers for the ARP CAM victim-index generator.
// Holds the FSM state enum, default Galois feedback masks and the LFSR step function.
package arp_cam_rnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } fsm_e;

  localparam logic [15:0] POLY_W16 = 16'hD35B;
  localparam logic [31:0] POLY_W32 = 32'h80200003;

  function automatic logic [63:0] default_poly(input int width);
    return (width == 32) ? 64'(POLY_W32) : 64'(POLY_W16);
  endfunction

  // Operands are zero-extended by the caller, so one 64-bit step serves every width.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state, input logic [63:0] poly);
    return (state >> 1) ^ (state[0] ? poly : 64'd0);
  endfunction

endpackage

// File: rtl/arp_cam_rnd_idx_if.sv
// Request/response and seed bus between the CAM controller (master) and the
// victim-index generator (slave).
interface arp_cam_rnd_idx_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
);
  logic             SeedLoad;
  logic [WIDTH-1:0] SeedVal;
  logic [WIDTH-1:0] Rnd;
  logic             ReqVld;
  logic             ReqRdy;
  logic             RspVld;
  logic             RspRdy;
  logic [IDX_W-1:0] RspIdx;
  logic             RspFallback;

  modport master (
    output SeedLoad, SeedVal, ReqVld, RspRdy,
    input  Rnd, ReqRdy, RspVld, RspIdx, RspFallback
  );

  modport slave (
    input  SeedLoad, SeedVal, ReqVld, RspRdy,
    output Rnd, ReqRdy, RspVld, RspIdx, RspFallback
  );
endinterface

// File: rtl/arp_cam_rnd_idx_lfsr.sv
// Free-running Galois LFSR with seed load. Define ARP_CAM_RND_LOCKUP_FIX_EN to
// replace a zero seed with all-ones, since zero is a fixed point of the register.
module arp_cam_lfsr
  import arp_cam_rnd_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH))
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             SeedLoad,
  input  logic [WIDTH-1:0] SeedVal,
  output logic [WIDTH-1:0] Rnd
);

  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] rnd_next;

`ifdef ARP_CAM_RND_LOCKUP_FIX_EN
  assign seed_eff = (SeedVal == '0) ? '1 : SeedVal;
`else
  assign seed_eff = SeedVal;
`endif

  assign rnd_next = WIDTH'(lfsr_next(64'(Rnd), 64'(POLY)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rnd <= '1;
    end else if (SeedLoad) begin
      Rnd <= seed_eff;
    end else begin
      Rnd <= rnd_next;
    end
  end

endmodule

// File: rtl/arp_cam_rnd_idx.sv
// Victim-index generator: draws LFSR candidates until one is <= IDX_MAX, falling back
// to a round-robin index after MAX_TRIES rejects. Optional macro: ARP_CAM_RND_LOCKUP_FIX_EN.
module arp_cam_rnd_idx
  import arp_cam_rnd_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(default_poly(WIDTH)),
  parameter int               IDX_W     = 4,
  parameter int               IDX_MAX   = 15,
  parameter int               MAX_TRIES = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  arp_cam_rnd_idx_if.slave  bus
);

  localparam logic [IDX_W-1:0] IDX_MAX_L  = IDX_W'(IDX_MAX);
  localparam logic [7:0]       TRIES_LAST = 8'(MAX_TRIES - 1);

  fsm_e             state_reg, state_next;
  logic [7:0]       tries_reg, tries_next;
  logic [IDX_W-1:0] rr_reg, rr_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             vld_reg, vld_next;
  logic             fb_reg, fb_next;
  logic [WIDTH-1:0] rnd;
  logic [IDX_W-1:0] cand;
  logic             in_range;

  arp_cam_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_lfsr (
    .Clk      (Clk),
    .Rst      (Rst),
    .SeedLoad (bus.SeedLoad),
    .SeedVal  (bus.SeedVal),
    .Rnd      (rnd)
  );

  // Candidate is the LFSR state before this edge's update.
  assign cand = rnd[IDX_W-1:0];

  // A full index range can never reject, so skip a comparison that is always true.
  generate
    if (IDX_MAX == (2 ** IDX_W) - 1) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (cand <= IDX_MAX_L);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    tries_next = tries_reg;
    rr_next    = rr_reg;
    idx_next   = idx_reg;
    vld_next   = vld_reg;
    fb_next    = fb_reg;
    case (state_reg)
      IDLE: begin
        if (bus.ReqVld) begin
          state_next = DRAW;
          tries_next = '0;
        end
      end
      DRAW: begin
        if (in_range) begin
          idx_next   = cand;
          fb_next    = 1'b0;
          vld_next   = 1'b1;
          state_next = HOLD;
        end else if (tries_reg == TRIES_LAST) begin
          idx_next   = rr_reg;
          fb_next    = 1'b1;
          vld_next   = 1'b1;
          rr_next    = (rr_reg == IDX_MAX_L) ? '0 : rr_reg + IDX_W'(1);
          state_next = HOLD;
        end else begin
          tries_next = tries_reg + 8'd1;
        end
      end
      HOLD: begin
        if (bus.RspRdy) begin
          vld_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      tries_reg <= '0;
      rr_reg    <= '0;
      idx_reg   <= '0;
      vld_reg   <= 1'b0;
      fb_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tries_reg <= tries_next;
      rr_reg    <= rr_next;
      idx_reg   <= idx_next;
      vld_reg   <= vld_next;
      fb_reg    <= fb_next;
    end
  end

  assign bus.Rnd         = rnd;
  assign bus.ReqRdy      = (state_reg == IDLE) && !Rst;
  assign bus.RspVld      = vld_reg;
  assign bus.RspIdx      = idx_reg;
  assign bus.RspFallback = fb_reg;

endmodule

// File: tb/tb_arp_cam_rnd_idx.sv
// Bench for arp_cam_rnd_idx: three instances (IDX_MAX/MAX_TRIES = 15/8, 9/8, 9/4) driven
// by directed and random requests, checked against a transaction-level reference model.
module tb_arp_cam_rnd_idx;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_vld   [ND];
  logic        rsp_rdy   [ND];
  logic        seed_load [ND];
  logic [15:0] seed_val  [ND];
  logic        req_rdy   [ND];
  logic        rsp_vld   [ND];
  logic        rsp_fb    [ND];
  logic [3:0]  rsp_idx   [ND];
  logic [15:0] rnd       [ND];

  int          imax_m  [ND] = '{15, 9, 9};
  int          tries_m [ND] = '{8, 8, 4};
  logic [15:0] rnd_m   [ND];
  int          rr_m    [ND];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int IMAX = (gi == 0) ? 15 : 9;
    localparam int MTRY = (gi == 2) ? 4 : 8;

    arp_cam_rnd_idx_if #(.WIDTH(16), .IDX_W(4)) bus ();

    arp_cam_rnd_idx #(
      .WIDTH     (16),
      .POLY      (16'hD35B),
      .IDX_W     (4),
      .IDX_MAX   (IMAX),
      .MAX_TRIES (MTRY)
    ) u_dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
    );

    assign bus.ReqVld   = req_vld[gi];
    assign bus.RspRdy   = rsp_rdy[gi];
    assign bus.SeedLoad = seed_load[gi];
    assign bus.SeedVal  = seed_val[gi];
    assign req_rdy[gi]  = bus.ReqRdy;
    assign rsp_vld[gi]  = bus.RspVld;
    assign rsp_fb[gi]   = bus.RspFallback;
    assign rsp_idx[gi]  = bus.RspIdx;
    assign rnd[gi]      = bus.Rnd;
  end

  function automatic logic [15:0] step(input logic [15:0] r);
    return {1'b0, r[15:1]} ^ (r[0] ? 16'hD35B : 16'h0000);
  endfunction

  function automatic logic [15:0] seed_fix(input logic [15:0] s);
`ifdef ARP_CAM_RND_LOCKUP_FIX_EN
    return (s == 16'h0000) ? 16'hFFFF : s;
`else
    return s;
`endif
  endfunction

  // Reference LFSR state, one per instance.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst)               rnd_m[d] <= 16'hFFFF;
      else if (seed_load[d]) rnd_m[d] <= seed_fix(seed_val[d]);
      else                   rnd_m[d] <= step(rnd_m[d]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk($sformatf("rnd[%0d]", d), 32'(rnd[d]), 32'(rnd_m[d]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_vld[%0d]", d), 32'(rsp_vld[d]), 0);
      chk($sformatf("rst_idx[%0d]", d), 32'(rsp_idx[d]), 0);
      chk($sformatf("rst_fb[%0d]", d),  32'(rsp_fb[d]), 0);
      chk($sformatf("rst_rdy[%0d]", d), 32'(req_rdy[d]), 0);
      chk($sformatf("rst_rnd[%0d]", d), 32'(rnd[d]), 32'h0000FFFF);
      rr_m[d] = 0;
    end
    rst = 1'b0;
    #1;
  endtask

  // One request on instance d. abort: 0 none, 1 reset while drawing, 2 reset while holding.
  task automatic do_req(input int d, input bit seed_en, input logic [15:0] seed,
                        input int hold, input int abort,
                        output logic [3:0] oidx, output logic ofb);
    logic [15:0] r;
    logic [3:0]  e_idx;
    logic        e_fb;
    int          k;
    #1;
    chk($sformatf("idle_rdy[%0d]", d), 32'(req_rdy[d]), 1);
    req_vld[d]   = 1'b1;
    seed_load[d] = seed_en;
    seed_val[d]  = seed;
    tick();
    req_vld[d]   = 1'b0;
    seed_load[d] = 1'b0;
    oidx = 4'd0;
    ofb  = 1'b0;
    // Walk the LFSR sequence from the state visible to the first draw.
    r = rnd_m[d];
    k = 0;
    e_idx = 4'd0;
    e_fb  = 1'b0;
    forever begin
      k++;
      if (int'(r[3:0]) <= imax_m[d]) begin
        e_idx = r[3:0];
        e_fb  = 1'b0;
        break;
      end
      if (k == tries_m[d]) begin
        e_idx = 4'(rr_m[d]);
        e_fb  = 1'b1;
        break;
      end
      r = step(r);
    end
    if (abort == 1) begin
      do_reset();
      return;
    end
    for (int i = 0; i < k; i++) begin
      chk($sformatf("draw_vld[%0d]", d), 32'(rsp_vld[d]), 0);
      chk($sformatf("draw_rdy[%0d]", d), 32'(req_rdy[d]), 0);
      tick();
    end
    chk($sformatf("rsp_vld[%0d]", d), 32'(rsp_vld[d]), 1);
    chk($sformatf("rsp_idx[%0d]", d), 32'(rsp_idx[d]), 32'(e_idx));
    chk($sformatf("rsp_fb[%0d]", d),  32'(rsp_fb[d]), 32'(e_fb));
    oidx = rsp_idx[d];
    ofb  = rsp_fb[d];
    if (e_fb) rr_m[d] = (rr_m[d] == imax_m[d]) ? 0 : rr_m[d] + 1;
    if (abort == 2) begin
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk($sformatf("hold_vld[%0d]", d), 32'(rsp_vld[d]), 1);
      chk($sformatf("hold_idx[%0d]", d), 32'(rsp_idx[d]), 32'(e_idx));
      chk($sformatf("hold_fb[%0d]", d),  32'(rsp_fb[d]), 32'(e_fb));
      chk($sformatf("hold_rdy[%0d]", d), 32'(req_rdy[d]), 0);
    end
    rsp_rdy[d] = 1'b1;
    tick();
    rsp_rdy[d] = 1'b0;
    chk($sformatf("done_vld[%0d]", d), 32'(rsp_vld[d]), 0);
    chk($sformatf("done_rdy[%0d]", d), 32'(req_rdy[d]), 1);
  endtask

  initial begin
    logic [3:0] idx;
    logic       fb;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req_vld[d] = 1'b0; rsp_rdy[d] = 1'b0; seed_load[d] = 1'b0; seed_val[d] = 16'h0; rr_m[d] = 0;
    end
    @(negedge clk);
    do_reset();

    // Reset release with an immediate request: FFFF -> ACA4, candidate 4.
    do_req(0, 1'b0, 16'h0, 0, 0, idx, fb);
    chk("t1_idx", 32'(idx), 32'h4);
    chk("t1_fb", 32'(fb), 0);

    // Seed 001E with IDX_MAX=9: E,F,C,E rejected, 7 accepted.
    do_req(1, 1'b1, 16'h001E, 0, 0, idx, fb);
    chk("t2_idx", 32'(idx), 32'h7);
    chk("t2_fb", 32'(fb), 0);

    // Same seed with MAX_TRIES=4: fallback, rr walks 0..9 and wraps.
    for (int i = 0; i < 11; i++) begin
      do_req(2, 1'b1, 16'h001E, 0, 0, idx, fb);
      chk("t3_idx", 32'(idx), 32'(i % 10));
      chk("t3_fb", 32'(fb), 1);
    end

    // Long hold with RspRdy low.
    do_req(0, 1'b0, 16'h0, 10, 0, idx, fb);

    // Reset while drawing, then while holding.
    do_req(1, 1'b1, 16'h001E, 0, 1, idx, fb);
    do_req(0, 1'b0, 16'h0, 0, 2, idx, fb);
    do_req(2, 1'b1, 16'h001E, 0, 0, idx, fb);
    chk("t5_rr_restart", 32'(idx), 0);

    // Zero seed.
    seed_load[0] = 1'b1;
    seed_val[0]  = 16'h0000;
    tick();
    seed_load[0] = 1'b0;
`ifdef ARP_CAM_RND_LOCKUP_FIX_EN
    chk("t6_rnd0", 32'(rnd[0]), 32'hFFFF);
    tick();
    chk("t6_rnd1", 32'(rnd[0]), 32'hACA4);
`else
    chk("t6_rnd0", 32'(rnd[0]), 32'h0000);
    tick();
    chk("t6_rnd1", 32'(rnd[0]), 32'h0000);
`endif
    do_req(0, 1'b0, 16'h0, 0, 0, idx, fb);
`ifndef ARP_CAM_RND_LOCKUP_FIX_EN
    chk("t6_idx", 32'(idx), 0);
    chk("t6_fb", 32'(fb), 0);
`endif
    do_reset();

    // Random requests, occasional reseeds and random hold lengths.
    for (int n = 0; n < 60; n++) begin
      do_req($urandom_range(0, ND - 1), ($urandom_range(0, 3) == 0), 16'($urandom),
             $urandom_range(0, 3), 0, idx, fb);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
